// File: rtl/reg_file_mp_sb.sv
// reg_file_mp_sb: multi-port register file with write-to-read bypass and busy scoreboard
module reg_file_mp_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NWR-1:0]      rf_en,
   input  logic [NWR*AW-1:0]   rd,
   input  logic [NWR*XLEN-1:0] wdata,
   input  logic [NRD*AW-1:0]   rs,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rs_busy,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_rd,
   output logic [NREGS-1:0]    busy_vec
);
   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d, clr;
   logic [AW-1:0]    wa [NWR];
   logic [AW-1:0]    ra [NRD];
   always_comb begin
      for (int k = 0; k < NWR; k++) wa[k] = rd[k*AW +: AW];
      for (int j = 0; j < NRD; j++) ra[j] = rs[j*AW +: AW];
   end
   // ascending port order lets the highest-index writer win
   always_comb begin
      regs_d = regs_q;
      clr = '0;
      for (int k = 0; k < NWR; k++) begin
         if (rf_en[k]) begin
            regs_d[wa[k]] = wdata[k*XLEN +: XLEN];
            clr[wa[k]] = 1'b1;
         end
      end
      if (ZERO_REG != 0) regs_d[0] = '0;
      busy_d = busy_q & ~clr;
      if (iss_en) busy_d[iss_rd] = 1'b1;
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end
   always_comb begin
      rdata = '0;
      rs_busy = '0;
      for (int j = 0; j < NRD; j++) begin
         rdata[j*XLEN +: XLEN] = regs_q[ra[j]];
         rs_busy[j] = busy_q[ra[j]];
         for (int k = 0; k < NWR; k++) begin
            if (BYPASS != 0 && rf_en[k] && wa[k] == ra[j] && !(ZERO_REG != 0 && ra[j] == '0)) begin
               rdata[j*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
               rs_busy[j] = 1'b0;
            end
         end
         if (ZERO_REG != 0 && ra[j] == '0) rdata[j*XLEN +: XLEN] = '0;
         if (!rst) begin
            rdata[j*XLEN +: XLEN] = '0;
            rs_busy[j] = 1'b0;
         end
      end
   end
   assign busy_vec = rst ? busy_q : '0;
endmodule

// File: tb/tb_reg_file_mp_sb.sv
// tb_reg_file_mp_sb: instance a (NWR=2, bypass, zero reg) and b (NWR=1, no bypass, no zero reg) vs a spec model
module tb_reg_file_mp_sb;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rf_en;
   logic [9:0]  rd;
   logic [63:0] wdata;
   logic [9:0]  rs;
   logic        iss_en;
   logic [4:0]  iss_rd;
   logic [63:0] rdata_a, rdata_b;
   logic [1:0]  rs_busy_a, rs_busy_b;
   logic [31:0] busy_vec_a, busy_vec_b;
   int total = 0;
   int bad = 0;
   logic [31:0] mem [2][32];
   logic [31:0] bsy [2];

   always #5 clk = ~clk;

   reg_file_mp_sb #(.NWR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .rf_en(rf_en), .rd(rd), .wdata(wdata), .rs(rs),
      .rdata(rdata_a), .rs_busy(rs_busy_a), .iss_en(iss_en), .iss_rd(iss_rd), .busy_vec(busy_vec_a));

   reg_file_mp_sb #(.NWR(1), .ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .rf_en(rf_en[0:0]), .rd(rd[4:0]), .wdata(wdata[31:0]), .rs(rs),
      .rdata(rdata_b), .rs_busy(rs_busy_b), .iss_en(iss_en), .iss_rd(iss_rd), .busy_vec(busy_vec_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // n=0: two writers, bypass, x0 hardwired; n=1: one writer, no bypass, x0 ordinary
   function automatic logic [31:0] exp_data(int n, logic [4:0] a);
      logic [31:0] v;
      v = mem[n][a];
      if (n == 0) begin
         if (a == 0) v = 0;
         else for (int k = 0; k < 2; k++) if (rf_en[k] && rd[k*5 +: 5] == a) v = wdata[k*32 +: 32];
      end
      return rst ? v : 32'h0;
   endfunction

   function automatic logic exp_busy(int n, logic [4:0] a);
      logic b;
      b = bsy[n][a];
      if (n == 0 && a != 0) for (int k = 0; k < 2; k++) if (rf_en[k] && rd[k*5 +: 5] == a) b = 1'b0;
      return rst & b;
   endfunction

   always @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (!rst) begin
            for (int i = 0; i < 32; i++) mem[n][i] = 0;
            bsy[n] = 0;
         end else begin
            for (int k = 0; k < (n == 0 ? 2 : 1); k++) begin
               if (rf_en[k]) begin
                  if (!(n == 0 && rd[k*5 +: 5] == 0)) mem[n][rd[k*5 +: 5]] = wdata[k*32 +: 32];
                  bsy[n][rd[k*5 +: 5]] = 1'b0;
               end
            end
            if (iss_en && !(n == 0 && iss_rd == 0)) bsy[n][iss_rd] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      for (int j = 0; j < 2; j++) begin
         chk($sformatf("cmp rdata_a[%0d]", j), rdata_a[j*32 +: 32], exp_data(0, rs[j*5 +: 5]));
         chk($sformatf("cmp rdata_b[%0d]", j), rdata_b[j*32 +: 32], exp_data(1, rs[j*5 +: 5]));
         chk($sformatf("cmp rs_busy_a[%0d]", j), {31'b0, rs_busy_a[j]}, {31'b0, exp_busy(0, rs[j*5 +: 5])});
         chk($sformatf("cmp rs_busy_b[%0d]", j), {31'b0, rs_busy_b[j]}, {31'b0, exp_busy(1, rs[j*5 +: 5])});
      end
      chk("cmp busy_vec_a", busy_vec_a, rst ? bsy[0] : 32'h0);
      chk("cmp busy_vec_b", busy_vec_b, rst ? bsy[1] : 32'h0);
   end

   task automatic drive(input logic r, input logic [1:0] en, input logic [4:0] d0, input logic [31:0] w0,
                        input logic [4:0] d1, input logic [31:0] w1, input logic [4:0] s0, input logic [4:0] s1,
                        input logic ie, input logic [4:0] ir);
      rst = r; rf_en = en; rd = {d1, d0}; wdata = {w1, w0}; rs = {s1, s0}; iss_en = ie; iss_rd = ir;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(0, 2'b11, 5, 32'h55, 5, 32'h66, 5, 3, 1, 3);
      chk("rst rdata_a", rdata_a[31:0], 32'h0);
      tick();
      drive(0, 2'b11, 5, 32'h55, 5, 32'h66, 5, 3, 1, 3);
      tick();
      drive(1, 2'b00, 0, 0, 0, 0, 5, 3, 0, 0);
      chk("rst busy_vec_a", busy_vec_a, 32'h0);
      chk("rst busy_vec_b", busy_vec_b, 32'h0);
      chk("rst rdata_b", rdata_b[63:32], 32'h0);
      tick();
      drive(1, 2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 0, 0, 0);
      chk("wr bypass_a", rdata_a[31:0], 32'hDEADBEEF);
      chk("wr nobypass_b", rdata_b[31:0], 32'h0);
      tick();
      drive(1, 2'b01, 0, 32'h1234, 0, 0, 5, 0, 0, 0);
      chk("rd x5_a", rdata_a[31:0], 32'hDEADBEEF);
      chk("rd x5_b", rdata_b[31:0], 32'hDEADBEEF);
      chk("model x5", mem[0][5], 32'hDEADBEEF);
      chk("x0 same cycle_a", rdata_a[63:32], 32'h0);
      tick();
      drive(1, 2'b11, 7, 32'h11, 7, 32'h22, 7, 0, 0, 0);
      chk("x0 stays 0_a", rdata_a[63:32], 32'h0);
      chk("x0 written_b", rdata_b[63:32], 32'h1234);
      chk("conflict bypass_a", rdata_a[31:0], 32'h22);
      tick();
      drive(1, 2'b01, 3, 32'hA, 0, 0, 7, 0, 0, 0);
      chk("conflict x7_a", rdata_a[31:0], 32'h22);
      chk("x7_b", rdata_b[31:0], 32'h11);
      tick();
      drive(1, 2'b01, 3, 32'hB, 0, 0, 3, 0, 0, 0);
      chk("nobypass old_b", rdata_b[31:0], 32'hA);
      chk("bypass new_a", rdata_a[31:0], 32'hB);
      tick();
      drive(1, 2'b00, 0, 0, 0, 0, 3, 9, 1, 9);
      chk("nobypass new_b", rdata_b[31:0], 32'hB);
      tick();
      drive(1, 2'b01, 9, 32'h99, 0, 0, 3, 9, 0, 0);
      chk("sb clear bypass_a", {31'b0, rs_busy_a[1]}, 32'h0);
      chk("sb clear nobypass_b", {31'b0, rs_busy_b[1]}, 32'h1);
      chk("sb busy9_a", busy_vec_a, 32'h200);
      tick();
      drive(1, 2'b00, 0, 0, 0, 0, 4, 9, 1, 4);
      chk("sb cleared_a", busy_vec_a, 32'h0);
      chk("model bsy cleared", bsy[0], 32'h0);
      tick();
      drive(1, 2'b01, 4, 32'h44, 0, 0, 4, 9, 1, 4);
      chk("collide pre_a", {31'b0, rs_busy_a[0]}, 32'h0);
      tick();
      drive(1, 2'b00, 0, 0, 0, 0, 4, 0, 1, 0);
      chk("collide busy_a", busy_vec_a, 32'h10);
      chk("collide data_a", rdata_a[31:0], 32'h44);
      chk("collide rs_busy_b", {31'b0, rs_busy_b[0]}, 32'h1);
      tick();
      drive(1, 2'b10, 0, 0, 12, 32'hC0FFEE, 4, 12, 0, 0);
      chk("iss x0_a", busy_vec_a, 32'h10);
      chk("iss x0_b", busy_vec_b, 32'h11);
      chk("p1 bypass_a", rdata_a[63:32], 32'hC0FFEE);
      tick();
      drive(0, 2'b11, 6, 32'h6, 8, 32'h8, 4, 12, 1, 6);
      chk("p1 x12_a", mem[0][12], 32'hC0FFEE);
      tick();
      drive(1, 2'b00, 0, 0, 0, 0, 4, 6, 0, 0);
      chk("midrst busy_a", busy_vec_a, 32'h0);
      chk("midrst busy_b", busy_vec_b, 32'h0);
      chk("midrst x4_a", rdata_a[31:0], 32'h0);
      chk("midrst x6_b", rdata_b[63:32], 32'h0);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
